// File: rtl/mac_accum_pkg.sv
// Shared constants, state encoding and lane arithmetic for the
// 64-lane Q8.8 multiply-accumulate stage.
package mac_accum_pkg;

    localparam int N     = 64;
    localparam int W     = 16;
    localparam int ACC_W = 20;
    localparam int CNT_W = 8;
    localparam int FRAC  = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [W-1:0]     lane_t;

    function automatic acc_t sat_acc(input acc_t a, input lane_t p);
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-W){p[W-1]}}, p};
        // Disagreeing top bits mean the add left the ACC_W range
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic lane_t clamp_out(input acc_t a, input logic relu);
        acc_t r;
        r = (relu && a[ACC_W-1]) ? '0 : a;
        if (r[ACC_W-1:W-1] == '0 || r[ACC_W-1:W-1] == '1)
            return r[W-1:0];
        return r[ACC_W-1] ? {1'b1, {(W-1){1'b0}}}
                          : {1'b0, {(W-1){1'b1}}};
    endfunction

endpackage

// File: rtl/mac_accum_if.sv
// Product-in / result-out handshake bundle of the accumulate stage.
interface mac_accum_if;
    import mac_accum_pkg::*;

    logic             start;
    logic [CNT_W-1:0] num_terms;
    logic             relu_en;
    logic             in_valid;
    logic             in_ready;
    logic [N*W-1:0]   prod_in;
    logic             out_valid;
    logic             out_ready;
    logic [N*W-1:0]   acc_out;
    logic             busy;

    modport master (
        output start, num_terms, relu_en, in_valid, prod_in, out_ready,
        input  in_ready, out_valid, acc_out, busy
    );

    modport slave (
        input  start, num_terms, relu_en, in_valid, prod_in, out_ready,
        output in_ready, out_valid, acc_out, busy
    );

endinterface

// File: rtl/mac_accum_lane.sv
// One lane: saturating accumulator plus registered ReLU/clamped result.
module mac_accum_lane
    import mac_accum_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  clr_i,
    input  logic  add_i,
    input  logic  load_i,
    input  logic  relu_i,
    input  lane_t prod_i,
    output lane_t res_o
);

    acc_t  acc_q, acc_d;
    lane_t res_q, res_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i)
            acc_d = '0;
        else if (add_i)
            acc_d = sat_acc(acc_q, prod_i);
        // Result is taken from the sum including the final beat
        res_d = load_i ? clamp_out(acc_d, relu_i) : res_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            res_q <= '0;
        end else begin
            acc_q <= acc_d;
            res_q <= res_d;
        end
    end

    assign res_o = res_q;

endmodule

// File: rtl/mac_accum.sv
// Accumulate stage top: FSM, term counter and handshake around N lanes.
module mac_accum
    import mac_accum_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    mac_accum_if.slave  bus
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             relu_q, relu_d;
    logic             in_ready_q, out_valid_q, busy_q;
    logic             clr, add, load, accept;
    logic [N*W-1:0]   res;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        relu_d  = relu_q;
        clr     = 1'b0;
        add     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            IDLE: ;
            ACCUM: begin
                if (accept) begin
                    add     = 1'b1;
                    count_d = count_q - 1'b1;
                    if (count_q == CNT_W'(1)) begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Start restarts from IDLE or aborts ACCUM, dropping any beat
        if (bus.start && state_q != DONE) begin
            clr     = 1'b1;
            add     = 1'b0;
            relu_d  = bus.relu_en;
            count_d = bus.num_terms;
            load    = (bus.num_terms == '0);
            state_d = (bus.num_terms == '0) ? DONE : ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            relu_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            relu_q      <= relu_d;
            in_ready_q  <= (state_d == ACCUM);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        mac_accum_lane u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (clr),
            .add_i  (add),
            .load_i (load),
            .relu_i (relu_d),
            .prod_i (bus.prod_in[i*W +: W]),
            .res_o  (res[i*W +: W])
        );
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.acc_out   = res;

endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: vector table, scoreboard queue
// and hand-written abort / backpressure / reset sequences.
module tb_mac_accum;
    import mac_accum_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mac_accum_if bus();

    mac_accum dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int           n;
        logic         relu;
        logic [W-1:0] p0, p1, pr;
        logic [W-1:0] e0, e1, er;
    } vec_t;

    localparam logic [W-1:0] ONE = 16'(1 << FRAC);

    vec_t           vt[8];
    logic [N*W-1:0] sbq[$];
    int             nvec = 0;
    int             nerr = 0;

    function automatic logic [N*W-1:0] build(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] c);
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++)
            v[i*W +: W] = (i == 0) ? a : (i == 1) ? b : c;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input logic [N*W-1:0] act,
                           input logic [N*W-1:0] exp);
        int f;
        nvec++;
        if (act !== exp) begin
            nerr++;
            f = -1;
            for (int i = N - 1; i >= 0; i--)
                if (act[i*W +: W] !== exp[i*W +: W]) f = i;
            $display("FAIL %s lane %0d: got %h want %h", nm, f,
                     act[f*W +: W], exp[f*W +: W]);
        end
    endtask

    task automatic start_tx(input int n, input logic relu, input logic iv);
        bus.start     = 1'b1;
        bus.num_terms = CNT_W'(n);
        bus.relu_en   = relu;
        bus.in_valid  = iv;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.relu_en  = ~relu;
    endtask

    task automatic feed(input int n, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 2000) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.prod_in  = bus.in_valid ? build(a, b, c)
                                        : build(16'h7777, 16'h7777, 16'h7777);
            if (bus.in_valid && bus.in_ready) got++;
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        if (got < n) begin
            nvec++;
            nerr++;
            $display("FAIL feed_timeout: got %0d beats want %0d", got, n);
        end
    endtask

    task automatic drain(input string nm);
        logic [N*W-1:0] e;
        int w = 0;
        while (!bus.out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s: scoreboard empty", nm);
            return;
        end
        e = sbq.pop_front();
        chk_res(nm, bus.acc_out, e);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({nm, "_vld_drop"}, 32'(bus.out_valid), 0);
        chk({nm, "_busy_drop"}, 32'(bus.busy), 0);
    endtask

    task automatic run_vec(input int k);
        sbq.push_back(build(vt[k].e0, vt[k].e1, vt[k].er));
        start_tx(vt[k].n, vt[k].relu, 1'b0);
        if (vt[k].n > 0) feed(vt[k].n, vt[k].p0, vt[k].p1, vt[k].pr);
        chk($sformatf("vec%0d_lat", k), 32'(bus.out_valid), 1);
        chk($sformatf("vec%0d_rdy", k), 32'(bus.in_ready), 0);
        drain($sformatf("vec%0d", k));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] held;

        bus.start     = 1'b0;
        bus.num_terms = '0;
        bus.relu_en   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.prod_in   = '0;
        bus.out_ready = 1'b0;

        vt[0] = '{3,   1'b0, ONE,     ONE,     ONE,
                       16'h0300, 16'h0300, 16'h0300};
        vt[1] = '{4,   1'b0, 16'h7000, 16'h9000, 16'h0000,
                       16'h7FFF, 16'h8000, 16'h0000};
        vt[2] = '{2,   1'b0, 16'hFF00, 16'hFF00, 16'hFF00,
                       16'hFE00, 16'hFE00, 16'hFE00};
        vt[3] = '{2,   1'b1, 16'hFF00, 16'hFF00, 16'hFF00,
                       16'h0000, 16'h0000, 16'h0000};
        vt[4] = '{0,   1'b0, 16'h1111, 16'h2222, 16'h3333,
                       16'h0000, 16'h0000, 16'h0000};
        vt[5] = '{255, 1'b0, 16'h7FFF, 16'h8000, 16'h0001,
                       16'h7FFF, 16'h8000, 16'h00FF};
        vt[6] = '{3,   1'b1, 16'h7000, 16'h9000, 16'h0080,
                       16'h7FFF, 16'h0000, 16'h0180};
        vt[7] = '{1,   1'b0, 16'h8000, 16'h7FFF, 16'hFFFF,
                       16'h8000, 16'h7FFF, 16'hFFFF};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk_res("rst_acc_out", bus.acc_out, '0);
        rst_n = 1'b1;

        // IDLE ignores in_valid
        bus.in_valid = 1'b1;
        bus.prod_in  = build(ONE, ONE, ONE);
        repeat (3) @(negedge clk);
        chk("idle_in_ready", 32'(bus.in_ready), 0);
        chk("idle_busy", 32'(bus.busy), 0);
        bus.in_valid = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(k);

        // Backpressure, with start in DONE ignored
        held = build(16'h0300, 16'h0300, 16'h0300);
        sbq.push_back(held);
        start_tx(3, 1'b0, 1'b0);
        feed(3, ONE, ONE, ONE);
        chk("bp_lat", 32'(bus.out_valid), 1);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.start     = (c == 1);
            bus.num_terms = '0;
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 1);
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk_res("bp_hold", bus.acc_out, held);
        end
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        drain("bp");
        chk_res("bp_retain", bus.acc_out, held);

        // Abort into num_terms=0 with a beat in the same cycle
        start_tx(5, 1'b0, 1'b0);
        feed(2, ONE, ONE, ONE);
        sbq.push_back('0);
        bus.prod_in = build(ONE, ONE, ONE);
        start_tx(0, 1'b0, 1'b1);
        chk("abort0_lat", 32'(bus.out_valid), 1);
        drain("abort0");

        // Abort into a fresh 1-term accumulation
        start_tx(5, 1'b1, 1'b0);
        feed(2, ONE, ONE, ONE);
        sbq.push_back(build(16'h0200, 16'h0200, 16'h0200));
        bus.prod_in = build(ONE, ONE, ONE);
        start_tx(1, 1'b0, 1'b1);
        feed(1, 16'h0200, 16'h0200, 16'h0200);
        chk("abort1_lat", 32'(bus.out_valid), 1);
        drain("abort1");

        // Reset in the middle of ACCUM
        start_tx(5, 1'b0, 1'b0);
        feed(2, ONE, ONE, ONE);
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        chk("mrst_out_valid", 32'(bus.out_valid), 0);
        chk("mrst_in_ready", 32'(bus.in_ready), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk_res("mrst_acc_out", bus.acc_out, '0);

        run_vec(0);

        if (sbq.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL sb_leftover: got %0d want 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
